// File: rtl/alu_sched_pkg.sv
// Shared opcode encodings, scheduler state type and opcode classification
// for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_PASS = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_XNOR = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_DIV  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between client blocks and the ALU scheduler.
// rsp_err exists only when ALU_DIVZERO_ERR_EN is defined.
interface alu_rr_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ID_W  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_opcode;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [2*WIDTH-1:0]    rsp_result;
`ifdef ALU_DIVZERO_ERR_EN
  logic                  rsp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
`else
  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
`endif

endinterface

// File: rtl/alu_rr_scheduler_core.sv
// Purely combinational ALU evaluator: opcode, a, b -> 2*WIDTH result plus
// a divide-by-zero indication.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]         opcode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               divzero_o
);

  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

  logic [WIDTH-1:0]   narrow;
  logic [2*WIDTH-1:0] wide;
  logic               use_wide;
  logic               shift_oor;

  assign shift_oor = ({1'b0, b_i} >= SHIFT_LIM);

  always_comb begin
    narrow    = '0;
    wide      = '0;
    use_wide  = 1'b0;
    divzero_o = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        // Carry lands in bit WIDTH because the sum is formed at 2*WIDTH.
        wide     = {{WIDTH{1'b0}}, a_i} + {{WIDTH{1'b0}}, b_i};
        use_wide = 1'b1;
      end
      OP_SUB:  narrow = a_i - b_i;
      OP_MUL: begin
        wide     = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        use_wide = 1'b1;
      end
      OP_INC:  narrow = a_i + WIDTH'(1);
      OP_DEC:  narrow = a_i - WIDTH'(1);
      OP_PASS: narrow = a_i;
      OP_NOT:  narrow = ~a_i;
      OP_AND:  narrow = a_i & b_i;
      OP_OR:   narrow = a_i | b_i;
      OP_XOR:  narrow = a_i ^ b_i;
      OP_NAND: narrow = ~(a_i & b_i);
      OP_NOR:  narrow = ~(a_i | b_i);
      OP_XNOR: narrow = ~(a_i ^ b_i);
      OP_SHL:  narrow = shift_oor ? '0 : (a_i << b_i);
      OP_SHR:  narrow = shift_oor ? '0 : (a_i >> b_i);
      OP_DIV: begin
        if (b_i == '0) begin
          narrow    = '1;
          divzero_o = 1'b1;
        end else begin
          narrow = a_i / b_i;
        end
      end
      default: narrow = '0;
    endcase
  end

  assign result_o = use_wide ? wide : {{WIDTH{1'b0}}, narrow};

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NREQ requesters.
// Define ALU_DIVZERO_ERR_EN to expose rsp_err for divide-by-zero.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned ID_W       = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          en,
  alu_rr_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MULDIV_LAT + 1);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [2*WIDTH-1:0] rsp_result_q;

  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic               grant_fire;
  logic [3:0]         grant_op;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_divzero;

  // Search from ptr+1 upward with wrap; the first hit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      idx  = (32'(ptr_q) + k) % NREQ;
      cand = ID_W'(idx);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_fire    = (state_q == IDLE) && en && !rst && grant_any;
  assign bus.req_ready = grant_fire ? (NREQ'(1) << grant_id) : '0;
  assign grant_op      = bus.req_opcode[4*grant_id +: 4];
  assign cnt_d         = is_multicycle(grant_op) ? CNT_W'(MULDIV_LAT) : CNT_W'(1);

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .opcode_i (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result),
    .divzero_o(alu_divzero)
  );

`ifdef ALU_DIVZERO_ERR_EN
  logic rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_divzero;
  assign unused_divzero = alu_divzero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(NREQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
`ifdef ALU_DIVZERO_ERR_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            op_q    <= grant_op;
            a_q     <= bus.req_a[WIDTH*grant_id +: WIDTH];
            b_q     <= bus.req_b[WIDTH*grant_id +: WIDTH];
            id_q    <= grant_id;
            ptr_q   <= grant_id;
            cnt_q   <= cnt_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_result_q <= alu_result;
            rsp_id_q     <= id_q;
`ifdef ALU_DIVZERO_ERR_EN
            rsp_err_q    <= alu_divzero;
`endif
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler (NREQ=4, WIDTH=16,
// MULDIV_LAT=4); rsp_err checks compile in under ALU_DIVZERO_ERR_EN.
module tb_alu_rr_scheduler;

  logic clk;
  logic rst;
  logic en;
  int   n_tests;
  int   n_fail;

  alu_rr_scheduler_if #(.NREQ(4), .WIDTH(16), .ID_W(2)) bus ();

  alu_rr_scheduler #(
    .NREQ(4),
    .WIDTH(16),
    .MULDIV_LAT(4),
    .ID_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
  endtask

  task automatic set_req(input int idx, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[idx]         = 1'b1;
    bus.req_opcode[4*idx +: 4] = op;
    bus.req_a[16*idx +: 16]    = a;
    bus.req_b[16*idx +: 16]    = b;
  endtask

  // Called right after the handshake edge; lat counts edges until rsp_valid.
  task automatic wait_rsp(output int lat, output logic [31:0] res,
                          output logic [1:0] id, output logic err);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    #1;
    res = bus.rsp_result;
    id  = bus.rsp_id;
`ifdef ALU_DIVZERO_ERR_EN
    err = bus.rsp_err;
`else
    err = 1'b0;
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        output int gw, output int lat, output logic [31:0] res,
                        output logic [1:0] id, output logic err);
    @(negedge clk);
    set_req(idx, op, a, b);
    gw = 0;
    #1;
    while (!bus.req_ready[idx] && gw < 20) begin
      @(negedge clk);
      #1;
      gw++;
    end
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    wait_rsp(lat, res, id, err);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    en            = 1'b1;
    bus.rsp_ready = 1'b0;
    clear_reqs();
    bus.req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    end
    n_tests++;
    if (bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id);
    end
    n_tests++;
    if (bus.rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", bus.rsp_result);
    end
`ifdef ALU_DIVZERO_ERR_EN
    n_tests++;
    if (bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err);
    end
`endif
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int gw, lat; logic [31:0] res; logic [1:0] id; logic err;
    run_op(0, 4'h0, 16'hFFFF, 16'h0001, gw, lat, res, id, err);
    n_tests++;
    if (gw !== 0) begin
      n_fail++; $display("FAIL add_grant_wait: got %0d expected 0", gw);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL add_latency: got %0d expected 1", lat);
    end
    n_tests++;
    if (res !== 32'h0001_0000) begin
      n_fail++; $display("FAIL add_result: got %h expected 00010000", res);
    end
    n_tests++;
    if (id !== 2'd0) begin
      n_fail++; $display("FAIL add_id: got %0d expected 0", id);
    end
  endtask

  task automatic test_fairness();
    logic [3:0]  got [6];
    int          at  [6];
    logic [1:0]  rid [6];
    logic [31:0] rres[6];
    logic [3:0]  e;
    int          ng, nr;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'h0, 16'(i), 16'd10);
    bus.rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      #1;
      if (bus.rsp_valid && nr < 6) begin
        rid[nr]  = bus.rsp_id;
        rres[nr] = bus.rsp_result;
        nr++;
      end
      if (bus.req_ready != 4'b0000) begin
        got[ng] = bus.req_ready;
        at[ng]  = cyc;
        ng++;
      end
      @(negedge clk);
    end
    clear_reqs();
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (ng !== 6) begin
      n_fail++; $display("FAIL fair_grant_count: got %0d expected 6", ng);
    end
    for (int i = 0; i < ng; i++) begin
      e = 4'b0001 << (i % 4);
      n_tests++;
      if (got[i] !== e) begin
        n_fail++; $display("FAIL fair_grant_%0d: got %b expected %b", i, got[i], e);
      end
      if (i > 0) begin
        n_tests++;
        if (at[i] - at[i-1] !== 3) begin
          n_fail++; $display("FAIL fair_spacing_%0d: got %0d expected 3", i, at[i] - at[i-1]);
        end
      end
    end
    n_tests++;
    if (nr !== 5) begin
      n_fail++; $display("FAIL fair_rsp_count: got %0d expected 5", nr);
    end
    for (int j = 0; j < nr && j < 5; j++) begin
      n_tests++;
      if (rid[j] !== 2'(j % 4) || rres[j] !== 32'(10 + (j % 4))) begin
        n_fail++;
        $display("FAIL fair_rsp_%0d: got id %0d result %0d expected id %0d result %0d",
                 j, rid[j], rres[j], j % 4, 10 + (j % 4));
      end
    end
  endtask

  task automatic test_multicycle();
    int gw, lat; logic [31:0] res; logic [1:0] id; logic err;
    run_op(1, 4'h2, 16'd300, 16'd200, gw, lat, res, id, err);
    n_tests++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected 4", lat);
    end
    n_tests++;
    if (res !== 32'd60000 || id !== 2'd1) begin
      n_fail++; $display("FAIL mul_result: got %0d id %0d expected 60000 id 1", res, id);
    end
    run_op(2, 4'hF, 16'd100, 16'd7, gw, lat, res, id, err);
    n_tests++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL div_latency: got %0d expected 4", lat);
    end
    n_tests++;
    if (res !== 32'd14 || id !== 2'd2) begin
      n_fail++; $display("FAIL div_result: got %0d id %0d expected 14 id 2", res, id);
    end
`ifdef ALU_DIVZERO_ERR_EN
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL div_err_clear: got %b expected 0", err);
    end
`endif
  endtask

  task automatic test_boundaries();
    int gw, lat; logic [31:0] res; logic [1:0] id; logic err;
    run_op(0, 4'hD, 16'd1, 16'd16, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL shl_oor: got %h lat %0d expected 0 lat 1", res, lat);
    end
    run_op(0, 4'h1, 16'd0, 16'd1, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL sub_wrap: got %h expected 0000ffff", res);
    end
    run_op(1, 4'h3, 16'hFFFF, 16'd0, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h0) begin
      n_fail++; $display("FAIL inc_wrap: got %h expected 0", res);
    end
    run_op(1, 4'hE, 16'h8000, 16'd15, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h1) begin
      n_fail++; $display("FAIL shr_15: got %h expected 1", res);
    end
    run_op(2, 4'hC, 16'h00FF, 16'h0F0F, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h0000_F00F) begin
      n_fail++; $display("FAIL xnor: got %h expected 0000f00f", res);
    end
    run_op(3, 4'hF, 16'd1234, 16'd0, gw, lat, res, id, err);
    n_tests++;
    if (res !== 32'h0000_FFFF || lat !== 4 || id !== 2'd3) begin
      n_fail++; $display("FAIL div_zero: got %h lat %0d id %0d expected 0000ffff lat 4 id 3", res, lat, id);
    end
`ifdef ALU_DIVZERO_ERR_EN
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL div_zero_err: got %b expected 1", err);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; logic [1:0] id; logic err;
    @(negedge clk);
    set_req(2, 4'h9, 16'h00F0, 16'h0FF0);
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_grant: got %b expected 0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    set_req(1, 4'h0, 16'd5, 16'd6);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL bp_latency: got %0d expected 1", lat);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h0000_0F00 ||
          bus.rsp_id !== 2'd2 || bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid %b result %h id %0d ready %b expected 1 00000f00 2 0000",
                 c, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_drain_nogrant: got %b expected 0000", bus.req_ready);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_after_drain: got valid %b ready %b expected 0 0010", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    clear_reqs();
    wait_rsp(lat, res, id, err);
    n_tests++;
    if (res !== 32'd11 || id !== 2'd1 || lat !== 1) begin
      n_fail++; $display("FAIL bp_next_op: got %0d id %0d lat %0d expected 11 id 1 lat 1", res, id, lat);
    end
  endtask

  task automatic test_enable();
    int lat; logic [31:0] res; logic [1:0] id; logic err;
    int grants;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'h7, 16'hFF00, 16'h0FF0);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) grants++;
      @(negedge clk);
    end
    n_tests++;
    if (grants !== 0) begin
      n_fail++; $display("FAIL en_low_grants: got %0d cycles with activity expected 0", grants);
    end
    en = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL en_high_grant: got %b expected 0100", bus.req_ready);
    end
    @(negedge clk);
    clear_reqs();
    wait_rsp(lat, res, id, err);
    n_tests++;
    if (res !== 32'h0000_0F00 || id !== 2'd2) begin
      n_fail++; $display("FAIL en_and_result: got %h id %0d expected 00000f00 id 2", res, id);
    end
  endtask

  task automatic test_reset_busy();
    int lat; logic [31:0] res; logic [1:0] id; logic err;
    int seen;
    @(negedge clk);
    set_req(3, 4'h2, 16'd3, 16'd5);
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL rb_grant: got %b expected 1000", bus.req_ready);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 ||
        bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rb_outputs: got valid %b result %h id %0d ready %b expected all 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.req_ready);
    end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (seen !== 0 || bus.rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL rb_no_response: got %0d responses result %h expected 0", seen, bus.rsp_result);
    end
    for (int i = 0; i < 4; i++) set_req(i, 4'h5, 16'(16'h1000 + i), 16'd0);
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rb_first_winner: got %b expected 0001", bus.req_ready);
    end
    @(negedge clk);
    clear_reqs();
    wait_rsp(lat, res, id, err);
    n_tests++;
    if (res !== 32'h0000_1000 || id !== 2'd0) begin
      n_fail++; $display("FAIL rb_pass_result: got %h id %0d expected 00001000 id 0", res, id);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    en      = 1'b1;
    bus.rsp_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single_add();
    test_fairness();
    test_multicycle();
    test_boundaries();
    test_backpressure();
    test_enable();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
